// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the IF/DM memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_e;

    localparam int unsigned MEM_LAT_DEFAULT   = 1;
    localparam int unsigned LAT_CNT_W_DEFAULT = $clog2(MEM_LAT_DEFAULT + 1);

    // Width of the read-latency counter; never narrower than one bit.
    function automatic int lat_cnt_w(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Combinational 2-way round-robin picker; the last-winner register lives in the parent.
module mem_arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  req_id_e    i_last,
    output logic [1:0] o_gnt,
    output req_id_e    o_winner
);

    always_comb begin
        o_winner = REQ_IF;
        case (i_req)
            2'b01:   o_winner = REQ_IF;
            2'b10:   o_winner = REQ_DM;
            2'b11:   o_winner = (i_last == REQ_IF) ? REQ_DM : REQ_IF;
            default: o_winner = REQ_IF;
        endcase
        o_gnt = {(o_winner == REQ_DM), (o_winner == REQ_IF)} & {2{|i_req}};
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access,
// one outstanding fixed-latency read at a time, round-robin on ties.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [AWIDTH-1:0] dm_addr_i,
    input  logic [DWIDTH-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [DWIDTH-1:0] dm_rdata_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i,
    output logic              busy_o
);

    localparam int CNT_W = lat_cnt_w(MEM_LAT);

    if (MEM_LAT < 1) begin : g_lat_chk
        $error("mem_arbiter: MEM_LAT must be >= 1");
    end

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    req_id_e           r_rr_last, r_owner, w_winner;
    logic [1:0]        w_req, w_gnt;
    logic              w_rd_start, w_rd_done;
    logic              r_if_rvalid, r_dm_rvalid;
    logic [DWIDTH-1:0] r_if_rdata, r_dm_rdata;

    // Requests are masked during reset so no grant escapes while rst is low.
    assign w_req     = {dm_req_i, if_req_i} & {2{rst}};
    assign w_rd_done = (r_state == RD_WAIT) && (r_cnt == CNT_W'(1));

    mem_arb_rr2 u_rr2 (
        .i_req    (w_req),
        .i_last   (r_rr_last),
        .o_gnt    (w_gnt),
        .o_winner (w_winner)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_rd_start     = 1'b0;
        if_gnt_o       = 1'b0;
        dm_gnt_o       = 1'b0;
        mem_addr_o     = '0;
        mem_data_o     = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_gnt) begin
                    if_gnt_o = w_gnt[0];
                    dm_gnt_o = w_gnt[1];
                    if (w_winner == REQ_DM) begin
                        mem_addr_o = dm_addr_i;
                        if (dm_we_i) begin
                            mem_write_en_o = 1'b1;
                            mem_data_o     = dm_wdata_i;
                        end else begin
                            w_rd_start = 1'b1;
                        end
                    end else begin
                        mem_addr_o = if_addr_i;
                        w_rd_start = 1'b1;
                    end
                    mem_read_en_o = w_rd_start;
                    if (w_rd_start) w_state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: if (w_rd_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_rr_last   <= REQ_IF;
            r_owner     <= REQ_IF;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            if (r_state == IDLE && |w_gnt) begin
                r_rr_last <= w_winner;
                if (w_rd_start) begin
                    r_cnt   <= CNT_W'(MEM_LAT);
                    r_owner <= w_winner;
                end
            end else if (r_state == RD_WAIT) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (w_rd_done) begin
                    if (r_owner == REQ_IF) begin
                        r_if_rvalid <= 1'b1;
                        r_if_rdata  <= mem_data_i;
                    end else begin
                        r_dm_rvalid <= 1'b1;
                        r_dm_rdata  <= mem_data_i;
                    end
                end
            end
        end
    end

    assign if_rvalid_o = r_if_rvalid;
    assign dm_rvalid_o = r_dm_rvalid;
    assign if_rdata_o  = r_if_rdata;
    assign dm_rdata_o  = r_dm_rdata;
    assign busy_o      = (r_state == RD_WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    logic        if_req = 0, dm_req = 0, dm_we = 0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, m_re, m_we, busy;
    logic [31:0] if_rdata, dm_rdata, m_addr, m_wdata, m_rdata;

    logic        if_req3 = 0, dm_req3 = 0, dm_we3 = 0;
    logic [31:0] if_addr3 = '0, dm_addr3 = '0, dm_wdata3 = '0;
    logic        if_gnt3, if_rvalid3, dm_gnt3, dm_rvalid3, m_re3, m_we3, busy3;
    logic [31:0] if_rdata3, dm_rdata3, m_addr3, m_wdata3, m_rdata3;

    always #5 clk = ~clk;

    mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
        .mem_addr_o(m_addr), .mem_data_o(m_wdata), .mem_read_en_o(m_re),
        .mem_write_en_o(m_we), .mem_data_i(m_rdata), .busy_o(busy)
    );

    mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .if_req_i(if_req3), .if_addr_i(if_addr3), .if_gnt_o(if_gnt3),
        .if_rvalid_o(if_rvalid3), .if_rdata_o(if_rdata3),
        .dm_req_i(dm_req3), .dm_we_i(dm_we3), .dm_addr_i(dm_addr3), .dm_wdata_i(dm_wdata3),
        .dm_gnt_o(dm_gnt3), .dm_rvalid_o(dm_rvalid3), .dm_rdata_o(dm_rdata3),
        .mem_addr_o(m_addr3), .mem_data_o(m_wdata3), .mem_read_en_o(m_re3),
        .mem_write_en_o(m_we3), .mem_data_i(m_rdata3), .busy_o(busy3)
    );

    // Fixed preload pattern for locations never written
    function automatic logic [31:0] mem_init(input logic [7:0] a);
        case (a)
            8'h10:   return 32'hDEADBEEF;
            8'h30:   return 32'hCAFEF00D;
            8'h40:   return 32'h55AA33CC;
            default: return {24'hA5A5A5, a};
        endcase
    endfunction

    logic [31:0]  m1 [256];
    logic [255:0] v1;
    logic [31:0]  q1, q3a, q3b, q3c;

    always @(posedge clk) begin
        if (!rst) v1 <= '0;
        else if (m_we) begin
            m1[m_addr[7:0]] <= m_wdata;
            v1[m_addr[7:0]] <= 1'b1;
        end
        q1 <= m_re ? (v1[m_addr[7:0]] ? m1[m_addr[7:0]] : mem_init(m_addr[7:0])) : 32'h0BAD0BAD;
    end
    assign m_rdata = q1;

    always @(posedge clk) begin
        q3a <= m_re3 ? mem_init(m_addr3[7:0]) : 32'h0BAD0BAD;
        q3b <= q3a;
        q3c <= q3b;
    end
    assign m_rdata3 = q3c;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        if_req = 0; dm_req = 0; dm_we = 0;
        cyc();
        rst = 0;
        cyc();
        rst = 1;
    endtask

    task automatic test_reset();
        if_req = 1; dm_req = 1;
        cyc();
        @(negedge clk);
        n_chk++; if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, m_re, m_we, busy} !== 7'b0) begin n_fail++;
            $display("FAIL reset_ctl: got %b expected 0000000", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, m_re, m_we, busy}); end
        n_chk++; if ({if_rdata, dm_rdata} !== 64'h0) begin n_fail++;
            $display("FAIL reset_rdata: got %h expected 0", {if_rdata, dm_rdata}); end
        n_chk++; if ({m_addr, m_wdata} !== 64'h0) begin n_fail++;
            $display("FAIL reset_membus: got %h expected 0", {m_addr, m_wdata}); end
        n_chk++; if ({if_gnt3, dm_gnt3, if_rvalid3, dm_rvalid3, m_re3, m_we3, busy3, if_rdata3, dm_rdata3} !== '0) begin n_fail++;
            $display("FAIL reset_lat3: got nonzero outputs expected 0"); end
        if_req = 0; dm_req = 0;
        cyc();
        rst = 1;
    endtask

    task automatic test_if_read();
        cyc();
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        n_chk++; if ({if_gnt, dm_gnt, m_re, m_we} !== 4'b1010) begin n_fail++;
            $display("FAIL ifrd_grant: got %b expected 1010", {if_gnt, dm_gnt, m_re, m_we}); end
        n_chk++; if (m_addr !== 32'h10) begin n_fail++;
            $display("FAIL ifrd_addr: got %h expected 00000010", m_addr); end
        cyc();
        if_req = 0;
        @(negedge clk);
        n_chk++; if ({busy, if_gnt, if_rvalid} !== 3'b100) begin n_fail++;
            $display("FAIL ifrd_busy: got %b expected 100", {busy, if_gnt, if_rvalid}); end
        cyc();
        @(negedge clk);
        n_chk++; if ({if_rvalid, busy} !== 2'b10 || if_rdata !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL ifrd_data: got rv=%b busy=%b data=%h expected rv=1 busy=0 data=deadbeef", if_rvalid, busy, if_rdata); end
        cyc();
        @(negedge clk);
        n_chk++; if (if_rvalid !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL ifrd_hold: got rv=%b data=%h expected rv=0 data=deadbeef", if_rvalid, if_rdata); end
    endtask

    task automatic test_dm_write();
        cyc();
        dm_req = 1; dm_we = 1; dm_addr = 32'h20; dm_wdata = 32'h12345678;
        @(negedge clk);
        n_chk++; if ({dm_gnt, if_gnt, m_we, m_re} !== 4'b1010) begin n_fail++;
            $display("FAIL dmwr_grant: got %b expected 1010", {dm_gnt, if_gnt, m_we, m_re}); end
        n_chk++; if (m_addr !== 32'h20 || m_wdata !== 32'h12345678) begin n_fail++;
            $display("FAIL dmwr_bus: got %h/%h expected 00000020/12345678", m_addr, m_wdata); end
        cyc();
        dm_req = 0; dm_we = 0;
        @(negedge clk);
        n_chk++; if ({dm_rvalid, busy, dm_gnt} !== 3'b000) begin n_fail++;
            $display("FAIL dmwr_norv: got %b expected 000", {dm_rvalid, busy, dm_gnt}); end
        cyc();
        dm_req = 1; dm_addr = 32'h20;
        @(negedge clk);
        n_chk++; if ({dm_gnt, m_re} !== 2'b11) begin n_fail++;
            $display("FAIL dmrd_grant: got %b expected 11", {dm_gnt, m_re}); end
        cyc();
        dm_req = 0;
        @(negedge clk);
        n_chk++; if (dm_rvalid !== 1'b0) begin n_fail++;
            $display("FAIL dmrd_early: got %b expected 0", dm_rvalid); end
        cyc();
        @(negedge clk);
        n_chk++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h12345678) begin n_fail++;
            $display("FAIL dmrd_data: got rv=%b data=%h expected rv=1 data=12345678", dm_rvalid, dm_rdata); end
    endtask

    task automatic test_alternate();
        logic [5:0] e_dm_gnt, e_if_gnt, e_busy, e_dm_rv, e_if_rv;
        e_dm_gnt = 6'b010001; e_if_gnt = 6'b000100; e_busy = 6'b101010;
        e_dm_rv  = 6'b000100; e_if_rv  = 6'b010000;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            cyc();
            if_req = 1; if_addr = 32'h10;
            dm_req = 1; dm_we = 0; dm_addr = 32'h30;
            @(negedge clk);
            n_chk++; if ({dm_gnt, if_gnt, busy, dm_rvalid, if_rvalid} !==
                         {e_dm_gnt[c], e_if_gnt[c], e_busy[c], e_dm_rv[c], e_if_rv[c]}) begin n_fail++;
                $display("FAIL alt_cycle%0d: got %b expected %b", c, {dm_gnt, if_gnt, busy, dm_rvalid, if_rvalid},
                         {e_dm_gnt[c], e_if_gnt[c], e_busy[c], e_dm_rv[c], e_if_rv[c]}); end
        end
        n_chk++; if (dm_rdata !== 32'hCAFEF00D || if_rdata !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL alt_rdata: got %h/%h expected cafef00d/deadbeef", dm_rdata, if_rdata); end
        cyc();
        if_req = 0; dm_req = 0;
        @(negedge clk);
        n_chk++; if (dm_rvalid !== 1'b1 || busy !== 1'b0) begin n_fail++;
            $display("FAIL alt_tail: got rv=%b busy=%b expected rv=1 busy=0", dm_rvalid, busy); end
    endtask

    task automatic test_reset_in_flight();
        cyc();
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        n_chk++; if (if_gnt !== 1'b1) begin n_fail++;
            $display("FAIL rif_grant: got %b expected 1", if_gnt); end
        cyc();
        if_req = 0;
        #1 rst = 0;
        #1;
        n_chk++; if ({busy, if_rvalid, dm_rvalid, m_re, m_we} !== 5'b0 || {if_rdata, dm_rdata} !== 64'h0) begin n_fail++;
            $display("FAIL rif_clear: got ctl=%b rdata=%h expected all 0", {busy, if_rvalid, dm_rvalid, m_re, m_we}, {if_rdata, dm_rdata}); end
        if_req = 1; dm_req = 1; dm_we = 0; dm_addr = 32'h30;
        @(negedge clk);
        n_chk++; if ({if_gnt, dm_gnt, m_re} !== 3'b000) begin n_fail++;
            $display("FAIL rif_nogrant: got %b expected 000", {if_gnt, dm_gnt, m_re}); end
        cyc();
        @(negedge clk);
        n_chk++; if ({if_gnt, dm_gnt, if_rvalid} !== 3'b000) begin n_fail++;
            $display("FAIL rif_hold: got %b expected 000", {if_gnt, dm_gnt, if_rvalid}); end
        cyc();
        rst = 1;
        @(negedge clk);
        n_chk++; if ({dm_gnt, if_gnt, if_rvalid} !== 3'b100 || m_addr !== 32'h30) begin n_fail++;
            $display("FAIL rif_tie_dm: got %b addr=%h expected 100 addr=00000030", {dm_gnt, if_gnt, if_rvalid}, m_addr); end
        cyc();
        if_req = 0; dm_req = 0;
        @(negedge clk);
        n_chk++; if ({busy, if_rvalid} !== 2'b10) begin n_fail++;
            $display("FAIL rif_busy: got %b expected 10", {busy, if_rvalid}); end
        cyc();
        @(negedge clk);
        n_chk++; if ({dm_rvalid, if_rvalid} !== 2'b10 || dm_rdata !== 32'hCAFEF00D) begin n_fail++;
            $display("FAIL rif_dmdata: got %b data=%h expected 10 data=cafef00d", {dm_rvalid, if_rvalid}, dm_rdata); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc();
        dm_req = 1; dm_we = 1; dm_addr = 32'h24; dm_wdata = 32'hA5A5A5A5;
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        n_chk++; if ({dm_gnt, if_gnt, m_we, m_re} !== 4'b1010 || m_wdata !== 32'hA5A5A5A5) begin n_fail++;
            $display("FAIL b2b_wr1: got %b data=%h expected 1010 data=a5a5a5a5", {dm_gnt, if_gnt, m_we, m_re}, m_wdata); end
        cyc();
        dm_addr = 32'h28; dm_wdata = 32'h5A5A5A5A;
        @(negedge clk);
        n_chk++; if ({dm_gnt, if_gnt, m_we, m_re} !== 4'b0101 || m_addr !== 32'h10) begin n_fail++;
            $display("FAIL b2b_ifrd: got %b addr=%h expected 0101 addr=00000010", {dm_gnt, if_gnt, m_we, m_re}, m_addr); end
        cyc();
        if_req = 0;
        @(negedge clk);
        n_chk++; if ({busy, dm_gnt, m_we} !== 3'b100) begin n_fail++;
            $display("FAIL b2b_wait: got %b expected 100", {busy, dm_gnt, m_we}); end
        cyc();
        @(negedge clk);
        n_chk++; if ({dm_gnt, m_we, if_rvalid} !== 3'b111 || m_addr !== 32'h28 || m_wdata !== 32'h5A5A5A5A) begin n_fail++;
            $display("FAIL b2b_wr2: got %b %h/%h expected 111 00000028/5a5a5a5a", {dm_gnt, m_we, if_rvalid}, m_addr, m_wdata); end
        n_chk++; if (if_rdata !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL b2b_ifdata: got %h expected deadbeef", if_rdata); end
        cyc();
        dm_req = 1; dm_we = 0; dm_addr = 32'h28;
        @(negedge clk);
        n_chk++; if ({dm_rvalid, dm_gnt, m_re} !== 3'b011) begin n_fail++;
            $display("FAIL b2b_rdback_gnt: got %b expected 011", {dm_rvalid, dm_gnt, m_re}); end
        cyc();
        dm_req = 0;
        cyc();
        @(negedge clk);
        n_chk++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h5A5A5A5A) begin n_fail++;
            $display("FAIL b2b_rdback: got rv=%b data=%h expected rv=1 data=5a5a5a5a", dm_rvalid, dm_rdata); end
    endtask

    task automatic test_lat3();
        cyc();
        dm_req3 = 1; dm_we3 = 0; dm_addr3 = 32'h40;
        @(negedge clk);
        n_chk++; if ({dm_gnt3, m_re3, m_we3} !== 3'b110 || m_wdata3 !== 32'h0) begin n_fail++;
            $display("FAIL l3_grant: got %b data=%h expected 110 data=0", {dm_gnt3, m_re3, m_we3}, m_wdata3); end
        cyc();
        dm_req3 = 0; if_req3 = 1; if_addr3 = 32'h10;
        for (int k = 1; k < 4; k++) begin
            if (k > 1) cyc();
            @(negedge clk);
            n_chk++; if ({busy3, if_gnt3, dm_rvalid3, m_re3} !== 4'b1000) begin n_fail++;
                $display("FAIL l3_wait%0d: got %b expected 1000", k, {busy3, if_gnt3, dm_rvalid3, m_re3}); end
        end
        cyc();
        @(negedge clk);
        n_chk++; if ({dm_rvalid3, if_gnt3, busy3} !== 3'b110 || dm_rdata3 !== 32'h55AA33CC) begin n_fail++;
            $display("FAIL l3_done: got %b data=%h expected 110 data=55aa33cc", {dm_rvalid3, if_gnt3, busy3}, dm_rdata3); end
        cyc();
        if_req3 = 0;
        @(negedge clk);
        n_chk++; if ({dm_rvalid3, busy3} !== 2'b01) begin n_fail++;
            $display("FAIL l3_ifbusy: got %b expected 01", {dm_rvalid3, busy3}); end
        for (int k = 6; k < 9; k++) begin
            cyc();
            @(negedge clk);
            n_chk++; if (if_rvalid3 !== (k == 8)) begin n_fail++;
                $display("FAIL l3_ifrv%0d: got %b expected %b", k, if_rvalid3, (k == 8)); end
        end
        n_chk++; if (if_rdata3 !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL l3_ifdata: got %h expected deadbeef", if_rdata3); end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_dm_write();
        test_alternate();
        test_reset_in_flight();
        test_back_to_back();
        test_lat3();
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
